// File: rtl/gps_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : gps_pkg                                                    |
// | Shared types, ASCII constants and hex helpers for the NMEA filter.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package gps_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_CK_HI   = 3'd2,
    S_CK_LO   = 3'd3,
    S_REPLAY  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_DOLLAR    = 8'h24;
  localparam logic [7:0] ASCII_STAR      = 8'h2A;
  localparam int         DEFAULT_MAX_LEN = 80;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Valid only for hex digits: letters (upper or lower) have bit 6 set and
  // their low nibble is 1..6, so adding 9 yields 10..15.
  function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
    return c[3:0] + (c[6] ? 4'd9 : 4'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nmea_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nmea_line_buffer                                           |
// | DEPTH x 8 line buffer, one write port, one registered read port.     |
// | Ports   : clk; we/wr_addr/wr_data write; rd_addr in, rd_data out     |
// |           (rd_data = mem[rd_addr] one clock later).                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module nmea_line_buffer #(
  parameter int DEPTH = 80,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/nmea_checksum_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nmea_checksum_filter                                       |
// | Captures NMEA sentences, verifies the XOR checksum and replays only  |
// | verified sentences ($, payload, *) as a byte stream.                 |
// | Ports   : clk, rst (sync, active high); rx_new/rx_data from UART;    |
// |           out_new/out_data to controller; sentence_ok/sentence_err   |
// |           pulses; busy during replay; good_cnt/bad_cnt statistics.   |
// | Option  : NMEA_FILTER_STATS_EN builds the saturating counters,       |
// |           otherwise good_cnt/bad_cnt are tied to 0.                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module nmea_checksum_filter
  import gps_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int GAP     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_new,
  input  logic [7:0]  rx_data,
  output logic        out_new,
  output logic [7:0]  out_data,
  output logic        sentence_ok,
  output logic        sentence_err,
  output logic        busy,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);          // len: 0..MAX_LEN
  localparam int RW = $clog2(MAX_LEN + 2);          // rp : 0..MAX_LEN+1
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t        state, state_d;
  logic [LW-1:0] len, len_d;
  logic [7:0]    xsum, xsum_d;
  logic [3:0]    hi, hi_d;
  logic [RW-1:0] rp, rp_d;            // replay position: 0='$', 1..len=payload, len+1='*'
  logic [15:0]   gap_cnt, gap_d;
  logic          new_d, ok_d, err_d, star_d, discard, we;
  logic [7:0]    data_d;
  logic [7:0]    rd_data;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] rd_idx;

  wire is_dollar = (rx_data == ASCII_DOLLAR);
  wire is_star   = (rx_data == ASCII_STAR);
  wire rx_hex    = is_hex(rx_data);
  wire [3:0] nib = hex_to_nibble(rx_data);

  always_comb begin
    state_d = state;
    len_d   = len;
    xsum_d  = xsum;
    hi_d    = hi;
    rp_d    = rp;
    gap_d   = gap_cnt;
    new_d   = 1'b0;
    data_d  = out_data;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    star_d  = 1'b0;
    discard = 1'b0;
    we      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_new && is_dollar) begin
          state_d = S_CAPTURE;
          len_d   = '0;
          xsum_d  = '0;
        end
      end
      S_CAPTURE: begin
        if (rx_new) begin
          if (is_star) begin
            state_d = S_CK_HI;
          end else if (is_dollar) begin
            err_d  = 1'b1;
            len_d  = '0;
            xsum_d = '0;
          end else if (len == LW'(MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            we     = 1'b1;
            len_d  = len + LW'(1);
            xsum_d = xsum ^ rx_data;
          end
        end
      end
      S_CK_HI, S_CK_LO: begin
        if (rx_new) begin
          if (rx_hex) begin
            if (state == S_CK_HI) begin
              hi_d    = nib;
              state_d = S_CK_LO;
            end else if ({hi, nib} == xsum) begin
              ok_d    = 1'b1;
              state_d = S_REPLAY;
              rp_d    = '0;
              gap_d   = '0;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            // A '$' in the checksum field starts a fresh sentence.
            err_d = 1'b1;
            if (is_dollar) begin
              state_d = S_CAPTURE;
              len_d   = '0;
              xsum_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_REPLAY: begin
        discard = rx_new;
        if (gap_cnt != '0) begin
          gap_d = gap_cnt - 16'd1;
        end else begin
          new_d = 1'b1;
          gap_d = 16'(GAP);
          rp_d  = rp + RW'(1);
          if (rp == '0) begin
            data_d = ASCII_DOLLAR;
          end else if (rp == (RW'(len) + RW'(1))) begin
            data_d  = ASCII_STAR;
            star_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            data_d = rd_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read address follows the next replay position so rd_data already holds
  // buf[rp-1] in the cycle a payload byte is emitted.
  always_comb begin
    rd_addr = '0;
    rd_idx  = rp_d - RW'(1);
    if (rp_d != '0 && rd_idx < RW'(MAX_LEN)) begin
      rd_addr = rd_idx[AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len          <= '0;
      xsum         <= '0;
      hi           <= '0;
      rp           <= '0;
      gap_cnt      <= '0;
      out_new      <= 1'b0;
      out_data     <= '0;
      sentence_ok  <= 1'b0;
      sentence_err <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      len          <= len_d;
      xsum         <= xsum_d;
      hi           <= hi_d;
      rp           <= rp_d;
      gap_cnt      <= gap_d;
      out_new      <= new_d;
      out_data     <= data_d;
      sentence_ok  <= ok_d;
      sentence_err <= err_d;
      // Held one extra cycle past S_REPLAY so it covers the '*' strobe.
      busy         <= (state_d == S_REPLAY) || star_d;
    end
  end

  nmea_line_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we      (we),
    .wr_addr (AW'(len)),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef NMEA_FILTER_STATS_EN
  logic [15:0] good_r, bad_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      good_r <= '0;
      bad_r  <= '0;
    end else begin
      if (ok_d && (good_r != 16'hFFFF)) begin
        good_r <= good_r + 16'd1;
      end
      if ((err_d || discard) && (bad_r != 16'hFFFF)) begin
        bad_r <= bad_r + 16'd1;
      end
    end
  end

  assign good_cnt = good_r;
  assign bad_cnt  = bad_r;
`else
  logic unused_discard;
  assign unused_discard = discard;
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nmea_checksum_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_nmea_checksum_filter                                    |
// | Directed bench: dut0 uses GAP=0, dut1 uses GAP=2.                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_nmea_checksum_filter;

`ifdef NMEA_FILTER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_new0 = 1'b0, rx_new1 = 1'b0;
  logic [7:0]  rx_data0 = 8'h00, rx_data1 = 8'h00;
  logic        out_new0, out_new1, ok0_o, ok1_o, err0_o, err1_o, busy0, busy1;
  logic [7:0]  out_data0, out_data1;
  logic [15:0] good0, good1, bad0, bad1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_k = 0;

  logic [7:0] q0[$], q1[$];
  int         t0[$], t1[$];
  int         okc0 = 0, errc0 = 0, okc1 = 0, errc1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nmea_checksum_filter #(.MAX_LEN(80), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .rx_new(rx_new0), .rx_data(rx_data0),
    .out_new(out_new0), .out_data(out_data0), .sentence_ok(ok0_o),
    .sentence_err(err0_o), .busy(busy0), .good_cnt(good0), .bad_cnt(bad0));

  nmea_checksum_filter #(.MAX_LEN(80), .GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .rx_new(rx_new1), .rx_data(rx_data1),
    .out_new(out_new1), .out_data(out_data1), .sentence_ok(ok1_o),
    .sentence_err(err1_o), .busy(busy1), .good_cnt(good1), .bad_cnt(bad1));

  // Record every strobe and pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_new0) begin q0.push_back(out_data0); t0.push_back(cyc); end
    if (out_new1) begin q1.push_back(out_data1); t1.push_back(cyc); end
    if (ok0_o)  okc0++;
    if (err0_o) errc0++;
    if (ok1_o)  okc1++;
    if (err1_o) errc1++;
  end

  // Returns -1 when q equals s, otherwise the first differing index.
  function automatic int seq_diff(input logic [7:0] q[$], input string s);
    if (q.size() != s.len()) return (q.size() < s.len()) ? q.size() : s.len();
    for (int i = 0; i < s.len(); i++) if (q[i] !== s[i]) return i;
    return -1;
  endfunction

  task automatic send(input int d, input logic [7:0] b);
    @(negedge clk);
    if (d == 0) begin rx_new0 = 1'b1; rx_data0 = b; end
    else        begin rx_new1 = 1'b1; rx_data1 = b; end
    last_k = cyc;
    @(negedge clk);
    rx_new0 = 1'b0;
    rx_new1 = 1'b0;
  endtask

  task automatic send_str(input int d, input string s);
    for (int i = 0; i < s.len(); i++) send(d, s[i]);
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q0.delete(); t0.delete(); q1.delete(); t1.delete();
    okc0 = 0; errc0 = 0; okc1 = 0; errc1 = 0;
  endtask

  task automatic test_reset();
    logic [63:0] got;
    restart();
    got = {out_new0, out_data0, ok0_o, err0_o, busy0, good0, bad0, 5'd0};
    vectors++;
    if (got !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_dut0: got %h, required 0", got);
    end
    got = {out_new1, out_data1, ok1_o, err1_o, busy1, good1, bad1, 5'd0};
    vectors++;
    if (got !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_dut1: got %h, required 0", got);
    end
  endtask

  task automatic test_good();
    int k, d;
    restart();
    send_str(0, "$AB*03");
    k = last_k;
    vectors++;
    if (ok0_o !== 1'b1 || busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL good_ok_k1: got ok=%b busy=%b, required ok=1 busy=1", ok0_o, busy0);
    end
    send_str(0, "\r\n");
    repeat (10) @(negedge clk);
    d = seq_diff(q0, "$AB*");
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL good_replay: got %0d bytes (diff at %0d), required \"$AB*\"", q0.size(), d);
    end
    vectors++;
    if (t0.size() != 4 || t0[0] != k + 2 || t0[3] != k + 5) begin
      miscompares++;
      $display("FAIL good_timing: got %0d strobes first at k+%0d, required 4 at k+2..k+5",
               t0.size(), (t0.size() > 0) ? t0[0] - k : -1);
    end
    vectors++;
    if (okc0 != 1 || errc0 != 0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL good_pulses: got ok=%0d err=%0d busy=%b, required 1 0 0", okc0, errc0, busy0);
    end
    vectors++;
    if (good0 !== 16'(STATS) || bad0 !== 16'd0) begin
      miscompares++;
      $display("FAIL good_counts: got good=%0d bad=%0d, required %0d 0", good0, bad0, STATS);
    end
  endtask

  task automatic test_bad_checksum();
    restart();
    send_str(0, "$AB*04");
    vectors++;
    if (err0_o !== 1'b1 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_err_k1: got err=%b busy=%b, required err=1 busy=0", err0_o, busy0);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (q0.size() != 0 || okc0 != 0 || errc0 != 1) begin
      miscompares++;
      $display("FAIL bad_output: got %0d strobes ok=%0d err=%0d, required 0 0 1", q0.size(), okc0, errc0);
    end
    vectors++;
    if (bad0 !== 16'(STATS) || good0 !== 16'd0) begin
      miscompares++;
      $display("FAIL bad_counts: got bad=%0d good=%0d, required %0d 0", bad0, good0, STATS);
    end
  endtask

  task automatic test_lowercase();
    int d;
    restart();
    send_str(0, "$J*4a");
    repeat (8) @(negedge clk);
    d = seq_diff(q0, "$J*");
    vectors++;
    if (d != -1 || okc0 != 1 || errc0 != 0) begin
      miscompares++;
      $display("FAIL lower_replay: got %0d bytes diff=%0d ok=%0d err=%0d, required \"$J*\" 1 0",
               q0.size(), d, okc0, errc0);
    end
  endtask

  task automatic test_restart();
    int d;
    restart();
    send_str(0, "$A$AB*03");
    repeat (10) @(negedge clk);
    d = seq_diff(q0, "$AB*");
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL restart_replay: got %0d bytes diff=%0d, required \"$AB*\"", q0.size(), d);
    end
    vectors++;
    if (okc0 != 1 || errc0 != 1) begin
      miscompares++;
      $display("FAIL restart_pulses: got ok=%0d err=%0d, required 1 1", okc0, errc0);
    end
  endtask

  task automatic test_zero_len();
    int d;
    restart();
    send_str(0, "$*00");
    repeat (8) @(negedge clk);
    d = seq_diff(q0, "$*");
    vectors++;
    if (d != -1 || okc0 != 1) begin
      miscompares++;
      $display("FAIL zero_len: got %0d bytes diff=%0d ok=%0d, required \"$*\" 1", q0.size(), d, okc0);
    end
  endtask

  task automatic test_max_len();
    string s;
    int d;
    restart();
    s = "$";
    for (int i = 0; i < 80; i++) s = {s, "A"};
    send_str(0, {s, "*00"});
    repeat (90) @(negedge clk);
    d = seq_diff(q0, {s, "*"});
    vectors++;
    if (d != -1 || okc0 != 1 || errc0 != 0) begin
      miscompares++;
      $display("FAIL max_len_replay: got %0d bytes diff=%0d ok=%0d err=%0d, required 82 bytes 1 0",
               q0.size(), d, okc0, errc0);
    end
    vectors++;
    if (t0.size() != 82 || t0[81] - t0[0] != 81) begin
      miscompares++;
      $display("FAIL max_len_spacing: got %0d strobes, required 82 back to back", t0.size());
    end
  endtask

  task automatic test_overflow();
    int d;
    restart();
    send(0, "$");
    for (int i = 0; i < 80; i++) send(0, "A");
    vectors++;
    if (errc0 != 0) begin
      miscompares++;
      $display("FAIL overflow_early: got err=%0d after 80 bytes, required 0", errc0);
    end
    send(0, "A");
    vectors++;
    if (err0_o !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_err_k1: got err=%b after byte 81, required 1", err0_o);
    end
    send_str(0, "*00");
    send_str(0, "$AB*03");
    repeat (10) @(negedge clk);
    d = seq_diff(q0, "$AB*");
    vectors++;
    if (d != -1 || okc0 != 1 || errc0 != 1) begin
      miscompares++;
      $display("FAIL overflow_recover: got %0d bytes diff=%0d ok=%0d err=%0d, required \"$AB*\" 1 1",
               q0.size(), d, okc0, errc0);
    end
  endtask

  task automatic test_gap();
    int k, d;
    restart();
    send_str(1, "$GP*17");
    k = last_k;
    repeat (3) @(negedge clk);
    rx_new1 = 1'b1;
    rx_data1 = "$";
    @(negedge clk);
    rx_new1 = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (busy1 !== 1'b1 || out_new1 !== 1'b1 || out_data1 !== "*") begin
      miscompares++;
      $display("FAIL gap_star_cycle: got busy=%b new=%b data=%h at k+%0d, required 1 1 2a at k+11",
               busy1, out_new1, out_data1, cyc - k);
    end
    @(negedge clk);
    vectors++;
    if (busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_busy_end: got busy=%b at k+12, required 0", busy1);
    end
    repeat (10) @(negedge clk);
    d = seq_diff(q1, "$GP*");
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL gap_replay: got %0d bytes diff=%0d, required \"$GP*\"", q1.size(), d);
    end
    vectors++;
    if (t1.size() != 4 || t1[0] != k + 2 || t1[1] != k + 5 || t1[2] != k + 8 || t1[3] != k + 11) begin
      miscompares++;
      $display("FAIL gap_timing: got %0d strobes first at k+%0d, required k+2,5,8,11",
               t1.size(), (t1.size() > 0) ? t1[0] - k : -1);
    end
    vectors++;
    if (okc1 != 1 || errc1 != 0 || bad1 !== 16'(STATS) || good1 !== 16'(STATS)) begin
      miscompares++;
      $display("FAIL gap_counts: got ok=%0d err=%0d bad=%0d good=%0d, required 1 0 %0d %0d",
               okc1, errc1, bad1, good1, STATS, STATS);
    end
  endtask

  task automatic test_reset_mid_replay();
    restart();
    send_str(0, "$AB*03");
    @(negedge clk);
    vectors++;
    if (out_new0 !== 1'b1 || out_data0 !== "$") begin
      miscompares++;
      $display("FAIL midrst_first: got new=%b data=%h, required 1 24", out_new0, out_data0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (q0.size() != 1 || busy0 !== 1'b0 || out_new0 !== 1'b0 || good0 !== 16'd0) begin
      miscompares++;
      $display("FAIL midrst_abort: got %0d strobes busy=%b good=%0d, required 1 0 0",
               q0.size(), busy0, good0);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_checksum();
    test_lowercase();
    test_restart();
    test_zero_len();
    test_max_len();
    test_overflow();
    test_gap();
    test_reset_mid_replay();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
